// File: rtl/des_pkg.sv
// Shared constants, tables, state enum and half-rotation helpers for the DES key schedule.
// The right-rotation helpers are consumed only when DES_KEY_SCHEDULE_DECRYPT_EN is defined.
package des_pkg;

    localparam int unsigned CD_WIDTH   = 56;
    localparam int unsigned HALF_WIDTH = 28;

    // Left-shift amount per round, index 1..16
    localparam int unsigned DES_SHIFT_SCHEDULE [1:16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // PC-1: output bit i (DES numbering) takes key bit PC1_TABLE[i]
    localparam int unsigned PC1_TABLE [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Shift amount for a 1-based round number
    function automatic logic [1:0] shift_amount(input logic [4:0] idx);
        return 2'(DES_SHIFT_SCHEDULE[idx]);
    endfunction

    function automatic logic [HALF_WIDTH-1:0] rotl_half(input logic [HALF_WIDTH-1:0] h,
                                                        input logic [1:0] s);
        return (s == 2'd2) ? {h[HALF_WIDTH-3:0], h[HALF_WIDTH-1:HALF_WIDTH-2]}
                           : {h[HALF_WIDTH-2:0], h[HALF_WIDTH-1]};
    endfunction

    function automatic logic [HALF_WIDTH-1:0] rotr_half(input logic [HALF_WIDTH-1:0] h,
                                                        input logic [1:0] s);
        return (s == 2'd2) ? {h[1:0], h[HALF_WIDTH-1:2]}
                           : {h[0], h[HALF_WIDTH-1:1]};
    endfunction

    // Rotate C and D independently; nothing crosses the half boundary
    function automatic logic [CD_WIDTH-1:0] rotl_cd(input logic [CD_WIDTH-1:0] cd,
                                                    input logic [1:0] s);
        return {rotl_half(cd[CD_WIDTH-1:HALF_WIDTH], s), rotl_half(cd[HALF_WIDTH-1:0], s)};
    endfunction

    function automatic logic [CD_WIDTH-1:0] rotr_cd(input logic [CD_WIDTH-1:0] cd,
                                                    input logic [1:0] s);
        return {rotr_half(cd[CD_WIDTH-1:HALF_WIDTH], s), rotr_half(cd[HALF_WIDTH-1:0], s)};
    endfunction

endpackage

// File: rtl/Permuted_Choice_1.sv
// Combinational DES PC-1: 64-bit key (bit n at index 65-n) to 56-bit C||D (bit n at index 57-n).
module Permuted_Choice_1
    import des_pkg::*;
(
    input  logic [64:1] key_i,
    output logic [56:1] cd_c_o
);

    // Pure wiring from the PC-1 table
    for (genvar i = 1; i <= 56; i++) begin : g_bit
        assign cd_c_o[57-i] = key_i[65-PC1_TABLE[i]];
    end

    // Parity bits take no part in the schedule
    logic unused_parity;
    assign unused_parity = ^{key_i[57], key_i[49], key_i[41], key_i[33],
                             key_i[25], key_i[17], key_i[9],  key_i[1]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 then per-round C/D rotation, one state per round under valid/advance.
// Optional reverse (decrypt) schedule enabled by macro DES_KEY_SCHEDULE_DECRYPT_EN.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 64,
    parameter int unsigned CD_WIDTH  = 56,
    parameter int unsigned ROUNDS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_WIDTH:1]   Key_Schedule_Input,
    input  logic                 Key_Schedule_Start,
    input  logic                 Key_Schedule_Advance,
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    input  logic                 Key_Schedule_Decrypt,
`endif
    output logic [CD_WIDTH:1]    Key_Schedule_Output,
    output logic [4:1]           Key_Schedule_Round,
    output logic                 Key_Schedule_Valid,
    output logic                 Key_Schedule_Busy,
    output logic                 Key_Schedule_Finish_Flag
);

    localparam int unsigned ROUND_WIDTH = 4;

    logic [CD_WIDTH:1]    pc1_c;
    ks_state_e            state_q, state_d;
    logic [CD_WIDTH:1]    cd_q, cd_d;
    logic [ROUND_WIDTH:1] round_q, round_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 finish_q, finish_d;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    logic                 dec_q, dec_d;
`endif

    Permuted_Choice_1 u_pc1 (
        .key_i  (Key_Schedule_Input),
        .cd_c_o (pc1_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        round_d  = round_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        finish_d = 1'b0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
        dec_d    = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Key_Schedule_Start) begin
                    state_d = ST_RUN;
                    round_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
                    dec_d   = Key_Schedule_Decrypt;
                    // Reverse schedule starts from the round-16 state, which is PC-1 itself
                    cd_d    = Key_Schedule_Decrypt ? pc1_c : rotl_cd(pc1_c, shift_amount(5'd1));
`else
                    cd_d    = rotl_cd(pc1_c, shift_amount(5'd1));
`endif
                end
            end
            ST_RUN: begin
                if (valid_q && Key_Schedule_Advance) begin
                    if (round_q == ROUND_WIDTH'(ROUNDS - 1)) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b0;
                        finish_d = 1'b1;
                    end else begin
                        round_d = round_q + 1'b1;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
                        // Undo the shift that produced the state currently presented
                        if (dec_q) cd_d = rotr_cd(cd_q, shift_amount(5'd16 - {1'b0, round_q}));
                        else       cd_d = rotl_cd(cd_q, shift_amount({1'b0, round_q} + 5'd2));
`else
                        cd_d = rotl_cd(cd_q, shift_amount({1'b0, round_q} + 5'd2));
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cd_q     <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
            dec_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
            dec_q    <= dec_d;
`endif
        end
    end

    assign Key_Schedule_Output      = cd_q;
    assign Key_Schedule_Round       = round_q;
    assign Key_Schedule_Valid       = valid_q;
    assign Key_Schedule_Busy        = busy_q;
    assign Key_Schedule_Finish_Flag = finish_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [64:1] key;
    logic        start;
    logic        adv;
    logic        dec;
    logic [56:1] ks_out;
    logic [4:1]  ks_round;
    logic        ks_valid;
    logic        ks_busy;
    logic        ks_fin;

    int errors = 0;
    int checks = 0;

    localparam logic [64:1] KEY    = 64'h133457799BBCDFF1;
    localparam logic [56:1] CD1    = 56'hE19955FAACCF1E;
    localparam logic [56:1] CD2    = 56'hC332ABF5599E3D;
    localparam logic [56:1] CD8    = 56'h2ABFC339E3D559;
    localparam logic [56:1] CD9    = 56'h557F8663C7AAB3;
    localparam logic [56:1] CD15   = 56'hF866557AAB33C7;
    localparam logic [56:1] CD16   = 56'hF0CCAAF556678F;
    localparam logic [48:1] K1     = 48'h1B02EFFC7072;
    localparam logic [48:1] K16    = 48'hCB3D8B0E17F5;

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk                      (clk),
        .rst                      (rst),
        .Key_Schedule_Input       (key),
        .Key_Schedule_Start       (start),
        .Key_Schedule_Advance     (adv),
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
        .Key_Schedule_Decrypt     (dec),
`endif
        .Key_Schedule_Output      (ks_out),
        .Key_Schedule_Round       (ks_round),
        .Key_Schedule_Valid       (ks_valid),
        .Key_Schedule_Busy        (ks_busy),
        .Key_Schedule_Finish_Flag (ks_fin)
    );

    // Reference PC-2 stage downstream of the schedule
    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] k;
        for (int i = 0; i < 48; i++) k[48-i] = cd[57-PC2_T[i]];
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; adv = 1'b0; dec = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; adv = 1'b0; dec = 1'b0; key = KEY;
        step(); step();
        rst = 1'b0;
        checks++; if (ks_out !== 56'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", ks_out); end
        checks++; if (ks_round !== 4'h0) begin errors++; $display("FAIL reset_round: got %0d expected 0", ks_round); end
        checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ks_valid); end
        checks++; if (ks_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ks_busy); end
        checks++; if (ks_fin !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", ks_fin); end
    endtask

    task automatic test_first_round();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (ks_out !== CD1) begin errors++; $display("FAIL first_out: got %h expected %h", ks_out, CD1); end
        checks++; if (ks_round !== 4'd0) begin errors++; $display("FAIL first_round: got %0d expected 0", ks_round); end
        checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", ks_valid); end
        checks++; if (ks_busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", ks_busy); end
        checks++; if (ks_fin !== 1'b0) begin errors++; $display("FAIL first_finish: got %b expected 0", ks_fin); end
        checks++; if (pc2(ks_out) !== K1) begin errors++; $display("FAIL first_k1: got %h expected %h", pc2(ks_out), K1); end
        adv = 1'b1; step(); adv = 1'b0;
        checks++; if (ks_out !== CD2) begin errors++; $display("FAIL second_out: got %h expected %h", ks_out, CD2); end
        checks++; if (ks_round !== 4'd1) begin errors++; $display("FAIL second_round: got %0d expected 1", ks_round); end
    endtask

    task automatic test_reset_mid();
        adv = 1'b1; step(); step(); adv = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        checks++; if (ks_out !== 56'h0) begin errors++; $display("FAIL midrst_out: got %h expected 0", ks_out); end
        checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ks_valid); end
        checks++; if (ks_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", ks_busy); end
        adv = 1'b1; step(); step(); adv = 1'b0;
        checks++; if (ks_round !== 4'd0) begin errors++; $display("FAIL midrst_adv_round: got %0d expected 0", ks_round); end
        checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL midrst_adv_valid: got %b expected 0", ks_valid); end
        checks++; if (ks_out !== 56'h0) begin errors++; $display("FAIL midrst_adv_out: got %h expected 0", ks_out); end
    endtask

    task automatic test_start_with_advance();
        do_reset();
        start = 1'b1; adv = 1'b1; step(); start = 1'b0; adv = 1'b0;
        checks++; if (ks_round !== 4'd0) begin errors++; $display("FAIL startadv_round: got %0d expected 0", ks_round); end
        checks++; if (ks_out !== CD1) begin errors++; $display("FAIL startadv_out: got %h expected %h", ks_out, CD1); end
    endtask

    task automatic test_back_to_back();
        int fin_seen;
        fin_seen = 0;
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        adv = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            step();
            if (ks_fin !== 1'b0) fin_seen++;
            checks++; if (ks_round !== 4'(r)) begin errors++; $display("FAIL b2b_round: got %0d expected %0d", ks_round, r); end
            if (r == 14) begin
                checks++; if (ks_out !== CD15) begin errors++; $display("FAIL b2b_cd15: got %h expected %h", ks_out, CD15); end
            end
        end
        checks++; if (ks_out !== CD16) begin errors++; $display("FAIL b2b_cd16: got %h expected %h", ks_out, CD16); end
        checks++; if (pc2(ks_out) !== K16) begin errors++; $display("FAIL b2b_k16: got %h expected %h", pc2(ks_out), K16); end
        checks++; if (fin_seen != 0) begin errors++; $display("FAIL b2b_early_finish: got %0d pulses expected 0", fin_seen); end
        step(); adv = 1'b0;
        checks++; if (ks_fin !== 1'b1) begin errors++; $display("FAIL b2b_finish: got %b expected 1", ks_fin); end
        checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid: got %b expected 0", ks_valid); end
        checks++; if (ks_busy !== 1'b1) begin errors++; $display("FAIL b2b_done_busy: got %b expected 1", ks_busy); end
        checks++; if (ks_out !== CD16 || ks_round !== 4'd15) begin errors++; $display("FAIL b2b_done_hold: got %h/%0d expected %h/15", ks_out, ks_round, CD16); end
        start = 1'b1; step();
        checks++; if (ks_fin !== 1'b0) begin errors++; $display("FAIL b2b_finish_width: got %b expected 0", ks_fin); end
        checks++; if (ks_busy !== 1'b0 || ks_valid !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got busy=%b valid=%b expected 0/0", ks_busy, ks_valid); end
        step(); start = 1'b0;
        checks++; if (ks_valid !== 1'b1 || ks_round !== 4'd0 || ks_out !== CD1) begin errors++; $display("FAIL b2b_restart: got v=%b r=%0d out=%h expected 1/0/%h", ks_valid, ks_round, ks_out, CD1); end
    endtask

    task automatic test_stall();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        adv = 1'b1; repeat (7) step(); adv = 1'b0;
        checks++; if (ks_round !== 4'd7) begin errors++; $display("FAIL stall_round: got %0d expected 7", ks_round); end
        checks++; if (ks_out !== CD8) begin errors++; $display("FAIL stall_cd8: got %h expected %h", ks_out, CD8); end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            checks++;
            if (ks_out !== CD8 || ks_round !== 4'd7 || ks_valid !== 1'b1 || ks_busy !== 1'b1 || ks_fin !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got out=%h r=%0d v=%b b=%b f=%b expected %h/7/1/1/0",
                         i, ks_out, ks_round, ks_valid, ks_busy, ks_fin, CD8);
            end
        end
        start = 1'b0;
        adv = 1'b1; step(); adv = 1'b0;
        checks++; if (ks_round !== 4'd8 || ks_out !== CD9) begin errors++; $display("FAIL stall_resume: got %0d/%h expected 8/%h", ks_round, ks_out, CD9); end
    endtask

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    task automatic test_decrypt();
        do_reset();
        dec = 1'b1; start = 1'b1; step(); start = 1'b0; dec = 1'b0;
        checks++; if (ks_out !== CD16) begin errors++; $display("FAIL dec_first: got %h expected %h", ks_out, CD16); end
        adv = 1'b1; step(); adv = 1'b0;
        checks++; if (ks_out !== CD15) begin errors++; $display("FAIL dec_second: got %h expected %h", ks_out, CD15); end
        adv = 1'b1; repeat (14) step(); adv = 1'b0;
        checks++; if (ks_out !== CD1 || ks_round !== 4'd15) begin errors++; $display("FAIL dec_last: got %h/%0d expected %h/15", ks_out, ks_round, CD1); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_round();
        test_reset_mid();
        test_start_with_advance();
        test_back_to_back();
        test_stall();
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
        test_decrypt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
